// File: rtl/sfx_sequencer_pkg.sv
// Shared definitions for the sound-effect sequencer and the buzzer tone generator:
// note codes, effect ids and ROM step field widths.
package sfx_sequencer_pkg;

  localparam int NOTE_W = 4;
  localparam int DUR_W  = 5;
  localparam int IDX_W  = 3;

  localparam logic [NOTE_W-1:0] NOTE_REST = 4'd0;
  localparam logic [NOTE_W-1:0] NOTE_C6   = 4'd1;
  localparam logic [NOTE_W-1:0] NOTE_D6   = 4'd2;
  localparam logic [NOTE_W-1:0] NOTE_E6   = 4'd3;
  localparam logic [NOTE_W-1:0] NOTE_F6   = 4'd4;
  localparam logic [NOTE_W-1:0] NOTE_G6   = 4'd5;
  localparam logic [NOTE_W-1:0] NOTE_B6   = 4'd6;
  localparam logic [NOTE_W-1:0] NOTE_C7   = 4'd7;
  localparam logic [NOTE_W-1:0] NOTE_G5   = 4'd8;
  localparam logic [NOTE_W-1:0] NOTE_F4   = 4'd9;
  localparam logic [NOTE_W-1:0] NOTE_B3   = 4'd10;

  // Numeric order doubles as priority order.
  typedef enum logic [1:0] {
    SFX_DROP    = 2'd0,
    SFX_INVALID = 2'd1,
    SFX_WIN     = 2'd2
  } sfx_id_e;

  typedef struct packed {
    logic [NOTE_W-1:0] note;
    logic [DUR_W-1:0]  dur;
  } sfx_step_t;

  function automatic sfx_id_e sfx_winner(input logic [2:0] req);
    if (req[2]) return SFX_WIN;
    if (req[1]) return SFX_INVALID;
    return SFX_DROP;
  endfunction

endpackage

// File: rtl/sfx_sequencer_rom.sv
// Effect sequence ROM: (id, step) -> {note, duration}, plus a flag telling the
// sequencer that the following step is the end of the effect.
module sfx_rom
  import sfx_sequencer_pkg::*;
(
  input  sfx_id_e          id_i,
  input  logic [IDX_W-1:0] step_i,
  output sfx_step_t        step_o,
  output logic             last_o
);

  function automatic logic [NOTE_W-1:0] note_of(input sfx_id_e id, input logic [IDX_W-1:0] idx);
    logic [NOTE_W-1:0] n;
    n = NOTE_REST;
    case (id)
      SFX_DROP:    case (idx) 3'd0: n = NOTE_C6; 3'd1: n = NOTE_G6; default: n = NOTE_REST; endcase
      SFX_INVALID: case (idx) 3'd0: n = NOTE_F4; 3'd2: n = NOTE_B3; default: n = NOTE_REST; endcase
      SFX_WIN:     case (idx)
                     3'd0: n = NOTE_C6;
                     3'd1: n = NOTE_E6;
                     3'd2: n = NOTE_G6;
                     3'd3: n = NOTE_C7;
                     default: n = NOTE_REST;
                   endcase
      default:     n = NOTE_REST;
    endcase
    return n;
  endfunction

  // A zero duration is the end marker.
  function automatic logic [DUR_W-1:0] dur_of(input sfx_id_e id, input logic [IDX_W-1:0] idx);
    logic [DUR_W-1:0] d;
    d = '0;
    case (id)
      SFX_DROP:    case (idx) 3'd0, 3'd1: d = 5'd5; default: d = '0; endcase
      SFX_INVALID: case (idx) 3'd0: d = 5'd10; 3'd1: d = 5'd3; 3'd2: d = 5'd15; default: d = '0; endcase
      SFX_WIN:     case (idx) 3'd0, 3'd1, 3'd2: d = 5'd8; 3'd3: d = 5'd20; default: d = '0; endcase
      default:     d = '0;
    endcase
    return d;
  endfunction

  assign step_o.note = note_of(id_i, step_i);
  assign step_o.dur  = dur_of(id_i, step_i);
  assign last_o      = (step_i == '1) || (dur_of(id_i, step_i + 3'd1) == '0);

endmodule

// File: rtl/sfx_sequencer.sv
// Sound-effect sequencer: fixed-priority arbitration of effect requests and
// tick-timed stepping through the effect ROM to drive the buzzer.
module sfx_sequencer
  import sfx_sequencer_pkg::*;
#(
  parameter int TICK_CYCLES = 250_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] sfx_req,
  input  logic       mute,
  output logic [3:0] note,
  output logic       note_en,
  output logic       busy,
  output logic [1:0] sfx_id,
  output logic       done
);

  localparam int            PW        = $clog2(TICK_CYCLES);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_CYCLES - 1);

  typedef enum logic {S_IDLE = 1'b0, S_PLAY = 1'b1} state_e;

  state_e           state_q, state_d;
  sfx_id_e          id_q, id_d;
  logic [IDX_W-1:0] step_q, step_d;
  logic [DUR_W-1:0] dur_q, dur_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             done_q, done_d;

  sfx_step_t cur;
  logic      cur_last;
  logic      tick, step_end, seq_end, start;
  sfx_id_e   req_id;

  sfx_rom u_rom (
    .id_i   (id_q),
    .step_i (step_q),
    .step_o (cur),
    .last_o (cur_last)
  );

  assign req_id   = sfx_winner(sfx_req);
  assign tick     = (state_q == S_PLAY) && (presc_q == PRESC_MAX);
  assign step_end = tick && ((dur_q + 5'd1) == cur.dur);
  assign seq_end  = step_end && cur_last;
  // A completing effect hands over to any request; otherwise only a strictly higher one preempts.
  assign start    = (|sfx_req) &&
                    ((state_q == S_IDLE) || seq_end || (req_id > id_q));

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    step_d  = step_q;
    dur_d   = dur_q;
    presc_d = presc_q;
    done_d  = seq_end;
    if (start) begin
      state_d = S_PLAY;
      id_d    = req_id;
      step_d  = '0;
      dur_d   = '0;
      presc_d = '0;
    end else begin
      case (state_q)
        S_PLAY: begin
          if (seq_end) begin
            state_d = S_IDLE;
            id_d    = SFX_DROP;
            step_d  = '0;
            dur_d   = '0;
            presc_d = '0;
          end else if (tick) begin
            presc_d = '0;
            if (step_end) begin
              step_d = step_q + 3'd1;
              dur_d  = '0;
            end else begin
              dur_d = dur_q + 5'd1;
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      id_q    <= SFX_DROP;
      step_q  <= '0;
      dur_q   <= '0;
      presc_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      step_q  <= step_d;
      dur_q   <= dur_d;
      presc_q <= presc_d;
      done_q  <= done_d;
    end
  end

  assign busy    = (state_q == S_PLAY);
  assign note    = busy ? cur.note : NOTE_REST;
  assign sfx_id  = busy ? id_q : 2'd0;
  assign note_en = busy && (cur.note != NOTE_REST) && !mute;
  assign done    = done_q;

endmodule

// File: tb/tb_sfx_sequencer.sv
// Bench for sfx_sequencer: elapsed-time effect model checked every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_sfx_sequencer;

  localparam int T = 4;
  localparam int DN [3][5] = '{'{1, 5, 0, 0, 0}, '{9, 0, 10, 0, 0}, '{1, 3, 5, 7, 0}};
  localparam int DD [3][5] = '{'{5, 5, 0, 0, 0}, '{10, 3, 15, 0, 0}, '{8, 8, 8, 20, 0}};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] sfx_req = 3'b000;
  logic       mute = 1'b0;
  logic [3:0] note;
  logic       note_en, busy, done;
  logic [1:0] sfx_id;
  logic       chk_en = 1'b0;
  int         n_chk = 0;
  int         n_fail = 0;

  sfx_sequencer #(.TICK_CYCLES(T)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sfx_req (sfx_req),
    .mute    (mute),
    .note    (note),
    .note_en (note_en),
    .busy    (busy),
    .sfx_id  (sfx_id),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int note_at(input int id, input int t);
    int acc;
    acc = 0;
    for (int s = 0; s < 5; s++) begin
      if (DD[id][s] == 0) return 0;
      acc += DD[id][s] * T;
      if (t < acc) return DN[id][s];
    end
    return 0;
  endfunction

  function automatic int total(input int id);
    int acc;
    acc = 0;
    for (int s = 0; s < 5; s++) acc += DD[id][s] * T;
    return acc;
  endfunction

  function automatic int top_req(input logic [2:0] r);
    if (r[2]) return 2;
    if (r[1]) return 1;
    if (r[0]) return 0;
    return -1;
  endfunction

  typedef struct packed {
    logic act;
    logic dn;
    int   id;
    int   t;
  } mstate_t;

  mstate_t m;

  function automatic mstate_t model_step(input mstate_t s, input logic [2:0] req);
    mstate_t n;
    int      hi;
    n    = s;
    n.dn = 1'b0;
    hi   = top_req(req);
    if (n.act) begin
      if (n.t + 1 == total(n.id)) begin
        n.dn  = 1'b1;
        n.act = 1'b0;
      end else begin
        n.t = n.t + 1;
      end
    end
    if (hi >= 0 && (!n.act || hi > n.id)) begin
      n.act = 1'b1;
      n.id  = hi;
      n.t   = 0;
    end
    if (!n.act) begin
      n.id = 0;
      n.t  = 0;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '0;
    else        m <= model_step(m, sfx_req);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", int'(busy), int'(m.act));
      check("sfx_id", int'(sfx_id), m.act ? m.id : 0);
      check("note", int'(note), m.act ? note_at(m.id, m.t) : 0);
      check("note_en", int'(note_en), (m.act && note_at(m.id, m.t) != 0 && !mute) ? 1 : 0);
      check("done", int'(done), int'(m.dn));
    end
  end

  task automatic pulse(input logic [2:0] r);
    @(posedge clk); #1 sfx_req = r;
    @(posedge clk); #1 sfx_req = 3'b000;
  endtask

  initial begin
    int n1, n5, n9, n9en, n10, nrest, nresten, ndone, done_at, busy_at_done, nbadid, nmuted_en;

    #12;
    check("reset_busy", int'(busy), 0);
    check("reset_note", int'(note), 0);
    check("reset_done", int'(done), 0);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Drop only
    pulse(3'b001);
    n1 = 0; n5 = 0; ndone = 0; done_at = -1; busy_at_done = 1;
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      if (busy && note == 4'd1) n1++;
      if (busy && note == 4'd5) n5++;
      if (done) begin
        ndone++;
        if (done_at < 0) begin done_at = i; busy_at_done = int'(busy); end
      end
    end
    check("drop_note1_clocks", n1, 20);
    check("drop_note5_clocks", n5, 20);
    check("drop_done_at", done_at, 40);
    check("drop_busy_at_done", busy_at_done, 0);
    check("drop_done_count", ndone, 1);

    // Invalid with rest step
    pulse(3'b010);
    n9 = 0; n9en = 0; n10 = 0; nrest = 0; nresten = 0; done_at = -1;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (busy && note == 4'd9) begin n9++; if (note_en) n9en++; end
      if (busy && note == 4'd10) n10++;
      if (busy && note == 4'd0) begin nrest++; if (note_en) nresten++; end
      if (done && done_at < 0) done_at = i;
    end
    check("inv_note9_clocks", n9, 40);
    check("inv_note9_enabled", n9en, 40);
    check("inv_rest_clocks", nrest, 12);
    check("inv_rest_enabled", nresten, 0);
    check("inv_note10_clocks", n10, 60);
    check("inv_done_at", done_at, 112);

    // Win preempts drop
    pulse(3'b001);
    ndone = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    pulse(3'b100);
    n1 = 0; done_at = -1;
    for (int i = 0; i < 180; i++) begin
      @(negedge clk);
      if (i == 0) check("preempt_id", int'(sfx_id), 2);
      if (busy && sfx_id == 2'd2 && note == 4'd1) n1++;
      if (done) begin ndone++; if (done_at < 0) done_at = i; end
    end
    check("preempt_note1_clocks", n1, 32);
    check("preempt_done_count", ndone, 1);
    check("preempt_done_at", done_at, 176);

    // Simultaneous requests from idle, lower priority ignored, mute mid-win
    pulse(3'b111);
    nbadid = 0; nmuted_en = 0; done_at = -1;
    for (int i = 0; i < 180; i++) begin
      @(negedge clk);
      if (busy && sfx_id != 2'd2) nbadid++;
      if (i >= 80 && i < 120 && note_en) nmuted_en++;
      if (i == 100) check("mute_note_seq", int'(note), 7);
      if (i == 100) check("mute_busy", int'(busy), 1);
      if (done && done_at < 0) done_at = i;
      if (i == 49) begin @(posedge clk); #1 sfx_req = 3'b001; end
      if (i == 50) begin @(posedge clk); #1 sfx_req = 3'b000; end
      if (i == 79) begin @(posedge clk); #1 mute = 1'b1; end
      if (i == 119) begin @(posedge clk); #1 mute = 1'b0; end
    end
    check("win_wrong_id_clocks", nbadid, 0);
    check("mute_note_en_clocks", nmuted_en, 0);
    check("win_done_at", done_at, 176);

    // Request on the completion edge, then async reset mid-step
    pulse(3'b001);
    for (int i = 0; i < 46; i++) begin
      @(negedge clk);
      if (i == 40) begin
        check("handover_done", int'(done), 1);
        check("handover_busy", int'(busy), 1);
        check("handover_id", int'(sfx_id), 1);
        check("handover_note", int'(note), 9);
      end
      if (i == 38) begin @(posedge clk); #1 sfx_req = 3'b010; end
      if (i == 39) begin @(posedge clk); #1 sfx_req = 3'b000; end
    end
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_note", int'(note), 0);
    check("rst_note_en", int'(note_en), 0);
    check("rst_sfx_id", int'(sfx_id), 0);
    check("rst_done", int'(done), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_rst_idle", int'(busy), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sfx_sequencer.md
# sfx_sequencer

Sound-effect sequencer that drives the buzzer tone generator's `note`/`enable` inputs. Game logic raises one-cycle requests for a drop, invalid-move or win effect. The block arbitrates by fixed priority and steps through a short ROM sequence of note codes and durations. Step timing comes from a tick prescaler, so effect lengths are exact multiples of `TICK_CYCLES` clocks.

## Interface
Parameters:
- `TICK_CYCLES`, 250_000 — clocks per duration tick (10 ms at 25 MHz); must be ≥ 2.

Ports:
- `clk`  in  1  system clock, 25 MHz.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `sfx_req`  in  3  request strobes: bit 0 drop, bit 1 invalid, bit 2 win; sampled every cycle.
- `mute`  in  1  forces `note_en` low; sequencing continues.
- `note`  out  4  note code to buzzer. 0 means rest; 1–10 are the buzzer codes C6, D6, E6, F6, G6, B6, C7, G5, F4, B3.
- `note_en`  out  1  buzzer enable.
- `busy`  out  1  effect playing.
- `sfx_id`  out  2  active effect: 0 drop, 1 invalid, 2 win; 0 when idle.
- `done`  out  1  one-cycle pulse on natural completion.

## Operation
- States: IDLE and PLAY.
- **IDLE.** Outputs `note`=0, `note_en`=0, `busy`=0.
- **IDLE → PLAY.**
  - Triggered when any `sfx_req` bit is set.
  - The highest set bit wins (win > invalid > drop).
  - Step index is set to 0, the duration counter to 0 and the prescaler to 0.
- **PLAY outputs.**
  - `note` = ROM note of the current step.
  - `note_en` = (`note` ≠ 0) && !`mute`.
  - `busy` = 1; `sfx_id` = latched id.
- **Duration counting.**
  - The prescaler counts 0..`TICK_CYCLES`-1 and emits a tick on its last count.
  - On each tick the duration counter increments.
  - When it reaches the step duration, the step advances and the duration counter clears.
  - Duration field is 5 bits (1–31 ticks). Duration 0 is the end marker.
- **End of sequence.** Advancing onto an end marker, or past step 7, returns to IDLE with `done`=1 for one cycle.
- **ROM contents** (note code, ticks):
  - Drop: (1,5) (5,5) end.
  - Invalid: (9,10) (0,3) (10,15) end.
  - Win: (1,8) (3,8) (5,8) (7,20) end.
- **Preemption.**
  - A request strictly higher in priority than the active id restarts at step 0 of the new effect on the next edge.
  - Prescaler and duration counter clear.
  - No `done` pulse for the preempted effect.
- **Ignored requests.** Requests of equal or lower priority during PLAY are ignored and not queued.
- **Request coinciding with natural completion.**
  - `done` pulses for the completing effect.
  - The highest pending request starts on the same edge, so `busy` stays 1.
- **Reset.** Reset at any point returns immediately to IDLE. All outputs go to 0, all counters to 0.

## Timing
- Request sampled at edge N. `busy`, `sfx_id` and the step-0 `note` are valid after edge N (cycle N+1).
- Each step lasts exactly duration × `TICK_CYCLES` clocks. There is no gap between steps, and rests are explicit ROM steps.
- `note`/`note_en` change only on step boundaries, preemption or mute.
- `mute` is combinational onto `note_en`. All other outputs are registered.
- Total clocks for each effect, request to `done`:
  - Drop: 10·T.
  - Invalid: 28·T.
  - Win: 44·T.
- `done` asserts in the cycle after the final tick, coincident with `busy` falling.

## Structure
- Shared package holds:
  - The note-code localparams, shared with the buzzer.
  - The effect ids.
  - The step field widths (4-bit note, 5-bit duration, 3-bit index).
- Sub-module `sfx_rom`: combinational lookup from (id, step) to {note, duration}.
- The top holds the FSM, prescaler, duration counter and arbiter.

## Test plan
All scenarios use `TICK_CYCLES`=4.
- **Drop only.** Pulse `sfx_req`=001.
  - `note`=1 for 20 clocks, then `note`=5 for 20 clocks.
  - `done` pulses once, 40 clocks after `busy` rises; `busy` falls with it.
- **Invalid, rest step.** Pulse 010.
  - `note_en` low for the 12-clock rest between `note` 9 (40 clocks) and `note` 10 (60 clocks).
- **Preempt.** Pulse 001, then 100 at clock 25.
  - `sfx_id`→2 and `note`=1 restarts for a full 32 clocks.
  - Exactly one `done`, at the end of the win effect.
- **Lower priority ignored, simultaneous requests.**
  - Pulse 001 during win: no change.
  - Pulse 111 from idle: win plays.
- **Mute and reset.**
  - `mute` high mid-win: `note_en`=0 while `note` keeps sequencing.
  - `rst_n` low mid-step: all outputs 0 asynchronously, and IDLE after release.
